// File: rtl/flash_test_seq_if.sv
// -----------------------------------------------------------------------------
// flash_test_seq_if
//   Command/completion bus between the flash test sequencer and the SPI flash
//   driver. The sequencer (master) presents one command at a time and holds it
//   until the driver (slave) pulses W_done_sig.
//
//   R_cmd_type   [4:0]        command class, 0 = no command
//   R_flash_cmd  [7:0]        flash opcode
//   R_flash_addr [ADDR_W-1:0] flash address
//   R_test_vec   [7:0]        byte to program
//   W_done_sig                driver completion pulse for the current command
//   W_read_data  [7:0]        byte returned by the driver, valid with W_done_sig
// -----------------------------------------------------------------------------
interface flash_test_seq_if #(
  parameter int ADDR_W = 24
);
  logic [4:0]        R_cmd_type;
  logic [7:0]        R_flash_cmd;
  logic [ADDR_W-1:0] R_flash_addr;
  logic [7:0]        R_test_vec;
  logic              W_done_sig;
  logic [7:0]        W_read_data;

  modport master (
    output R_cmd_type, R_flash_cmd, R_flash_addr, R_test_vec,
    input  W_done_sig, W_read_data
  );

  modport slave (
    input  R_cmd_type, R_flash_cmd, R_flash_addr, R_test_vec,
    output W_done_sig, W_read_data
  );
endinterface

// File: rtl/flash_test_seq.sv
// -----------------------------------------------------------------------------
// flash_test_seq
//   Flash self-test sequencer. On I_start it programs NUM_BYTES bytes starting
//   at START_ADDR with a selected data pattern (WREN, one-byte program, status
//   poll per byte), then reads every byte back and counts mismatches.
//
//   Optional feature: define FLASH_SEQ_ERASE_EN to insert a sector erase
//   (WREN, D8 at START_ADDR, status poll) before the program loop.
//
// Ports
//   clk_25M        sole clock, rising edge
//   I_rst          synchronous active-high reset
//   I_start        one-cycle start pulse, honoured only when idle
//   I_pattern[1:0] 0: 0x00, 1: 0xFF, 2: addr[7:0], 3: ~addr[7:0]
//   bus            command bus to the flash driver (master side)
//   R_busy         high from accepted start until DONE is entered
//   R_done         one-cycle completion pulse
//   R_err_cnt      verify mismatches, saturating
//   R_timeout      sticky: a status poll ran out of POLL_MAX attempts
// -----------------------------------------------------------------------------
module flash_test_seq #(
  parameter int ADDR_W     = 24,
  parameter int START_ADDR = 0,
  parameter int NUM_BYTES  = 256,
  parameter int POLL_MAX   = 65535
) (
  input  logic             clk_25M,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic [1:0]       I_pattern,
  flash_test_seq_if.master bus,
  output logic             R_busy,
  output logic             R_done,
  output logic [15:0]      R_err_cnt,
  output logic             R_timeout
);

  // Command classes and opcodes
  localparam logic [4:0] CT_WREN  = 5'b1_0001;
  localparam logic [4:0] CT_ERASE = 5'b1_0010;
  localparam logic [4:0] CT_RDSR  = 5'b1_0011;
  localparam logic [4:0] CT_READ  = 5'b1_0100;
  localparam logic [4:0] CT_PROG  = 5'b1_1000;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_ERASE = 8'hD8;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PROG  = 8'h32;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(START_ADDR + NUM_BYTES - 1);
  localparam logic [31:0]       POLL_LAST  = 32'(POLL_MAX - 1);

`ifdef FLASH_SEQ_ERASE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_ERASE, S_PROG, S_POLL, S_READ, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_PROG, S_POLL, S_READ, S_DONE
  } state_t;
`endif

  state_t            state, state_d;
  logic              gap;          // idle cycle after every completed command
  logic [1:0]        pat_q;
  logic [ADDR_W-1:0] addr_cnt;
  logic [31:0]       poll_cnt;     // busy status replies seen in this wait
  logic              erase_pend;   // erase still ahead of the program loop

  logic [4:0]        cmd_type;
  logic [7:0]        flash_cmd;
  logic [ADDR_W-1:0] flash_addr;
  logic [7:0]        test_vec;
  logic [7:0]        exp_byte;
  logic              acc;
  logic              start_acc;
  logic              rd_busy;
  logic              addr_last;
  logic              poll_last;

  // Pattern byte for the current counter address
  always_comb begin
    exp_byte = 8'h00;
    case (pat_q)
      2'd0:    exp_byte = 8'h00;
      2'd1:    exp_byte = 8'hFF;
      2'd2:    exp_byte = addr_cnt[7:0];
      default: exp_byte = ~addr_cnt[7:0];
    endcase
  end

  // Command outputs: decoded from state, forced to zero during the gap cycle
  always_comb begin
    cmd_type   = 5'd0;
    flash_cmd  = 8'h00;
    flash_addr = '0;
    test_vec   = 8'h00;
    if (!gap) begin
      case (state)
        S_WREN: begin
          cmd_type  = CT_WREN;
          flash_cmd = OP_WREN;
        end
`ifdef FLASH_SEQ_ERASE_EN
        S_ERASE: begin
          cmd_type   = CT_ERASE;
          flash_cmd  = OP_ERASE;
          flash_addr = FIRST_ADDR;
        end
`endif
        S_PROG: begin
          cmd_type   = CT_PROG;
          flash_cmd  = OP_PROG;
          flash_addr = addr_cnt;
          test_vec   = exp_byte;
        end
        S_POLL: begin
          cmd_type  = CT_RDSR;
          flash_cmd = OP_RDSR;
        end
        S_READ: begin
          cmd_type   = CT_READ;
          flash_cmd  = OP_READ;
          flash_addr = addr_cnt;
        end
        default: ;
      endcase
    end
  end

  assign bus.R_cmd_type   = cmd_type;
  assign bus.R_flash_cmd  = flash_cmd;
  assign bus.R_flash_addr = flash_addr;
  assign bus.R_test_vec   = test_vec;

  // A done pulse only counts while a command is actually presented
  assign acc       = (cmd_type != 5'd0) && bus.W_done_sig;
  assign start_acc = (state == S_IDLE) && I_start;
  assign rd_busy   = bus.W_read_data[0];
  assign addr_last = (addr_cnt == LAST_ADDR);
  assign poll_last = (poll_cnt == POLL_LAST);

  assign R_busy = (state != S_IDLE) && (state != S_DONE);
  assign R_done = (state == S_DONE);

  // State register
  always_ff @(posedge clk_25M) begin
    if (I_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (I_start) state_d = S_WREN;
      S_WREN: begin
        if (acc) begin
`ifdef FLASH_SEQ_ERASE_EN
          state_d = erase_pend ? S_ERASE : S_PROG;
`else
          state_d = S_PROG;
`endif
        end
      end
`ifdef FLASH_SEQ_ERASE_EN
      S_ERASE: if (acc) state_d = S_POLL;
`endif
      S_PROG: if (acc) state_d = S_POLL;
      S_POLL: begin
        if (acc) begin
          if (rd_busy) begin
            // stay and reissue RDSR after the gap, unless out of attempts
            if (poll_last) state_d = S_DONE;
          end else if (erase_pend) begin
            state_d = S_WREN;
          end else if (addr_last) begin
            state_d = S_READ;
          end else begin
            state_d = S_WREN;
          end
        end
      end
      S_READ: if (acc && addr_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: address counter, poll counter, error count, sticky timeout
  always_ff @(posedge clk_25M) begin
    if (I_rst) begin
      gap       <= 1'b0;
      pat_q     <= 2'd0;
      addr_cnt  <= '0;
      poll_cnt  <= '0;
      R_err_cnt <= 16'd0;
      R_timeout <= 1'b0;
    end else begin
      gap <= acc;

      if (start_acc) begin
        pat_q     <= I_pattern;
        addr_cnt  <= FIRST_ADDR;
        R_err_cnt <= 16'd0;
        R_timeout <= 1'b0;
      end

      if (state != S_POLL)
        poll_cnt <= '0;
      else if (acc && rd_busy)
        poll_cnt <= poll_cnt + 32'd1;

      if ((state == S_POLL) && acc && rd_busy && poll_last)
        R_timeout <= 1'b1;

      // Program wait finished: advance, or rewind for the verify pass
      if ((state == S_POLL) && acc && !rd_busy && !erase_pend)
        addr_cnt <= addr_last ? FIRST_ADDR : addr_cnt + ADDR_W'(1);

      if ((state == S_READ) && acc) begin
        if (!addr_last)
          addr_cnt <= addr_cnt + ADDR_W'(1);
        if ((bus.W_read_data != exp_byte) && (R_err_cnt != 16'hFFFF))
          R_err_cnt <= R_err_cnt + 16'd1;
      end
    end
  end

`ifdef FLASH_SEQ_ERASE_EN
  always_ff @(posedge clk_25M) begin
    if (I_rst)
      erase_pend <= 1'b0;
    else if (start_acc)
      erase_pend <= 1'b1;
    else if ((state == S_POLL) && acc && !rd_busy)
      erase_pend <= 1'b0;
  end
`else
  assign erase_pend = 1'b0;
`endif

endmodule

// File: tb/tb_flash_test_seq.sv
// -----------------------------------------------------------------------------
// tb_flash_test_seq
//   Drives flash_test_seq with a behavioural flash driver, records every
//   command the sequencer issues and compares the trace, error count and
//   timeout flag with a list built directly from the sequencing rules.
// -----------------------------------------------------------------------------
module tb_flash_test_seq;
  localparam int ADDR_W     = 24;
  localparam int START_ADDR = 'h100;
  localparam int NUM_BYTES  = 4;
  localparam int POLL_MAX   = 8;
  localparam int BUDGET     = 3000;
  localparam int NWAIT      = NUM_BYTES + 1;

  localparam logic [4:0] CT_WREN  = 5'b1_0001;
  localparam logic [4:0] CT_ERASE = 5'b1_0010;
  localparam logic [4:0] CT_RDSR  = 5'b1_0011;
  localparam logic [4:0] CT_READ  = 5'b1_0100;
  localparam logic [4:0] CT_PROG  = 5'b1_1000;

  typedef struct packed {
    logic [4:0]        ct;
    logic [7:0]        op;
    logic [ADDR_W-1:0] ad;
    logic [7:0]        tv;
  } cmd_t;

  logic        clk_25M = 1'b0;
  logic        I_rst, I_start;
  logic [1:0]  I_pattern;
  logic        R_busy, R_done, R_timeout;
  logic [15:0] R_err_cnt;

  flash_test_seq_if #(.ADDR_W(ADDR_W)) bus ();

  flash_test_seq #(
    .ADDR_W(ADDR_W), .START_ADDR(START_ADDR),
    .NUM_BYTES(NUM_BYTES), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk_25M  (clk_25M),
    .I_rst    (I_rst),
    .I_start  (I_start),
    .I_pattern(I_pattern),
    .bus      (bus.master),
    .R_busy   (R_busy),
    .R_done   (R_done),
    .R_err_cnt(R_err_cnt),
    .R_timeout(R_timeout)
  );

  always #20 clk_25M = ~clk_25M;

  int   checks = 0;
  int   errors = 0;
  cmd_t log_q[$];
  cmd_t exp_q[$];
  int   busy_tab [NWAIT];
  logic [7:0] corrupt [NUM_BYTES];
  logic [1:0] run_pat;
  int   wait_idx, read_idx, busy_left, hold_left, gap_bad, stable_bad;
  bit   holding, prev_done;
  cmd_t snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pat_byte(input logic [1:0] p, input logic [ADDR_W-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    case (p)
      2'd0:    return 8'h00;
      2'd1:    return 8'hFF;
      2'd2:    return lo;
      default: return ~lo;
    endcase
  endfunction

  function automatic cmd_t mk(input logic [4:0] ct, input logic [7:0] op,
                              input logic [ADDR_W-1:0] ad, input logic [7:0] tv);
    cmd_t c;
    c.ct = ct; c.op = op; c.ad = ad; c.tv = tv;
    return c;
  endfunction

  // Only the fields that mean something for a command class are compared
  function automatic cmd_t canon(input cmd_t c);
    cmd_t r;
    r = c;
    if (!(c.ct inside {CT_PROG, CT_READ, CT_ERASE})) r.ad = '0;
    if (c.ct != CT_PROG) r.tv = 8'h00;
    return r;
  endfunction

  // One status wait: busy replies then a ready reply, capped at POLL_MAX reads
  task automatic add_polls(input int nbusy, output bit tmo);
    int n;
    tmo = (nbusy >= POLL_MAX);
    n   = tmo ? POLL_MAX : nbusy + 1;
    for (int k = 0; k < n; k++) exp_q.push_back(mk(CT_RDSR, 8'h05, '0, 8'h00));
  endtask

  task automatic build_exp(input logic [1:0] p, output bit tmo, output int nerr);
    int w;
    logic [ADDR_W-1:0] a;
    w = 0; tmo = 0; nerr = 0;
    exp_q.delete();
`ifdef FLASH_SEQ_ERASE_EN
    exp_q.push_back(mk(CT_WREN, 8'h06, '0, 8'h00));
    exp_q.push_back(mk(CT_ERASE, 8'hD8, ADDR_W'(START_ADDR), 8'h00));
    add_polls(busy_tab[0], tmo);
    w = 1;
    if (tmo) return;
`endif
    for (int i = 0; i < NUM_BYTES; i++) begin
      a = ADDR_W'(START_ADDR + i);
      exp_q.push_back(mk(CT_WREN, 8'h06, '0, 8'h00));
      exp_q.push_back(mk(CT_PROG, 8'h32, a, pat_byte(p, a)));
      add_polls(busy_tab[w], tmo);
      w++;
      if (tmo) return;
    end
    for (int i = 0; i < NUM_BYTES; i++) begin
      exp_q.push_back(mk(CT_READ, 8'h03, ADDR_W'(START_ADDR + i), 8'h00));
      if (corrupt[i] != 8'h00) nerr++;
    end
  endtask

  // Flash driver model: called once per cycle at the falling edge
  task automatic step();
    cmd_t c;
    c.ct = bus.R_cmd_type; c.op = bus.R_flash_cmd;
    c.ad = bus.R_flash_addr; c.tv = bus.R_test_vec;
    if (prev_done && c.ct != 5'd0) gap_bad++;
    prev_done = 0;
    bus.W_done_sig  = 1'b0;
    bus.W_read_data = 8'($urandom);
    if (c.ct == 5'd0) begin
      holding = 0;
      // stray completion while nothing is presented must be ignored
      if ($urandom_range(0, 3) == 0) bus.W_done_sig = 1'b1;
    end else begin
      if (!holding) begin
        holding   = 1;
        snap      = c;
        hold_left = $urandom_range(0, 2);
        log_q.push_back(canon(c));
        if (c.ct == CT_PROG || c.ct == CT_ERASE) begin
          busy_left = (wait_idx < NWAIT) ? busy_tab[wait_idx] : 0;
          wait_idx++;
        end
      end else if (c != snap) begin
        stable_bad++;
      end
      if (hold_left == 0) begin
        bus.W_done_sig = 1'b1;
        holding   = 0;
        prev_done = 1;
        if (c.ct == CT_RDSR) begin
          bus.W_read_data[0] = (busy_left > 0);
          if (busy_left > 0) busy_left--;
        end else if (c.ct == CT_READ) begin
          bus.W_read_data = pat_byte(run_pat, c.ad) ^
                            ((read_idx < NUM_BYTES) ? corrupt[read_idx] : 8'h00);
          read_idx++;
        end
      end else begin
        hold_left--;
      end
    end
  endtask

  task automatic reset_model();
    log_q.delete();
    wait_idx = 0; read_idx = 0; busy_left = 0; hold_left = 0;
    holding = 0; prev_done = 0; gap_bad = 0; stable_bad = 0;
    bus.W_done_sig = 1'b0;
  endtask

  task automatic do_run(input string name, input logic [1:0] p, input bit poke_start);
    bit tmo, fin;
    int nerr, dcnt, cyc, n;
    run_pat = p;
    build_exp(p, tmo, nerr);
    reset_model();
    I_pattern = p; I_start = 1'b1;
    @(negedge clk_25M);
    I_start = 1'b0; I_pattern = ~p;
    chk({name, ":busy_start"}, 64'(R_busy), 64'd1);
    dcnt = 0; cyc = 0; fin = 0;
    while (!fin && cyc < BUDGET) begin
      I_start = poke_start && (cyc == 6);
      if (R_done) begin
        dcnt++; fin = 1;
        chk({name, ":busy_at_done"}, 64'(R_busy), 64'd0);
      end
      step();
      @(negedge clk_25M);
      cyc++;
    end
    I_start = 1'b0;
    if (!fin) chk({name, ":cycle_budget"}, 64'd0, 64'd1);
    for (int k = 0; k < 3; k++) begin
      if (R_done) dcnt++;
      step();
      @(negedge clk_25M);
    end
    bus.W_done_sig = 1'b0;
    chk({name, ":done_pulses"}, 64'(dcnt), 64'd1);
    chk({name, ":err_cnt"}, 64'(R_err_cnt), 64'(nerr));
    chk({name, ":timeout"}, 64'(R_timeout), 64'(tmo));
    chk({name, ":n_cmds"}, 64'(log_q.size()), 64'(exp_q.size()));
    chk({name, ":idle_gap"}, 64'(gap_bad), 64'd0);
    chk({name, ":held_stable"}, 64'(stable_bad), 64'd0);
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s:cmd%0d", name, i), 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  task automatic set_tabs(input int b, input logic [7:0] m);
    for (int i = 0; i < NWAIT; i++) busy_tab[i] = b;
    for (int i = 0; i < NUM_BYTES; i++) corrupt[i] = m;
  endtask

  task automatic chk_zero(input string name);
    chk({name, ":cmd_type"}, 64'(bus.R_cmd_type), 64'd0);
    chk({name, ":flash_cmd"}, 64'(bus.R_flash_cmd), 64'd0);
    chk({name, ":flash_addr"}, 64'(bus.R_flash_addr), 64'd0);
    chk({name, ":test_vec"}, 64'(bus.R_test_vec), 64'd0);
    chk({name, ":busy"}, 64'(R_busy), 64'd0);
    chk({name, ":done"}, 64'(R_done), 64'd0);
    chk({name, ":err_cnt"}, 64'(R_err_cnt), 64'd0);
    chk({name, ":timeout"}, 64'(R_timeout), 64'd0);
  endtask

  initial begin
    int cyc;
    I_rst = 1'b1; I_start = 1'b0; I_pattern = 2'd0;
    bus.W_done_sig = 1'b0; bus.W_read_data = 8'h00;
    repeat (3) @(negedge clk_25M);
    chk_zero("reset");
    I_rst = 1'b0;
    @(negedge clk_25M);

    // Address pattern, flash ready at once
    set_tabs(0, 8'h00);
    do_run("addr_pat", 2'd2, 1'b0);

    // Two busy replies before ready on every wait
    set_tabs(2, 8'h00);
    do_run("busy2", 2'd0, 1'b0);

    // All-FF pattern, second byte reads back as FE
    set_tabs(1, 8'h00);
    corrupt[1] = 8'h01;
    do_run("bad_byte", 2'd1, 1'b0);

    // Flash never becomes ready: timeout, no verify reads
    set_tabs(1000, 8'h00);
    do_run("stuck", 2'd3, 1'b0);

    // Reset in idle clears the sticky results
    I_rst = 1'b1;
    @(negedge clk_25M);
    I_rst = 1'b0;
    chk_zero("idle_reset");

    // Reset while a program command is presented
    set_tabs(0, 8'h00);
    reset_model();
    run_pat = 2'd3;
    I_pattern = 2'd3; I_start = 1'b1;
    @(negedge clk_25M);
    I_start = 1'b0;
    cyc = 0;
    while (bus.R_cmd_type != CT_PROG && cyc < BUDGET) begin
      step();
      @(negedge clk_25M);
      cyc++;
    end
    if (cyc >= BUDGET) chk("abort:reach_prog", 64'd0, 64'd1);
    bus.W_done_sig = 1'b0;
    I_rst = 1'b1;
    @(negedge clk_25M);
    chk_zero("abort");
    I_start = 1'b1;
    @(negedge clk_25M);
    I_rst = 1'b0; I_start = 1'b0;
    @(negedge clk_25M);
    chk("rst_start:busy", 64'(R_busy), 64'd0);
    chk("rst_start:cmd_type", 64'(bus.R_cmd_type), 64'd0);
    do_run("restart", 2'd3, 1'b0);

    // Randomized runs, some with a start pulse arriving mid-run
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NWAIT; i++) busy_tab[i] = $urandom_range(0, 3);
      if (r == 5) busy_tab[$urandom_range(0, NWAIT - 1)] = 1000;
      for (int i = 0; i < NUM_BYTES; i++)
        corrupt[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_run($sformatf("rand%0d", r), 2'($urandom_range(0, 3)), r[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flash_test_seq.md
FLASH_TEST_SEQ -- requirements
Module: flash_test_seq

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 24, flash address width; START_ADDR, default 0, first test address; NUM_BYTES, default 256, bytes tested (1..2^ADDR_W-START_ADDR); POLL_MAX, default 65535, max status reads per busy wait.
REQ-002 clk_25M  input  1  sole clock; all logic on rising edge.
REQ-003 I_rst  input  1  reset, synchronous, active-high.
REQ-004 I_start  input  1  one-cycle pulse; begins a test run when idle.
REQ-005 I_pattern  input  2  data mode: 0 all-0x00, 1 all-0xFF, 2 address[7:0], 3 ~address[7:0]; sampled on accepted I_start.
REQ-006 W_done_sig  input  1  driver completion pulse for current command.
REQ-007 W_read_data  input  8  driver read byte, valid when W_done_sig=1.
REQ-008 R_cmd_type  output  5  driver command class; 0 = no command.
REQ-009 R_flash_cmd  output  8  flash opcode.
REQ-010 R_flash_addr  output  ADDR_W  flash address.
REQ-011 R_test_vec  output  8  byte to program.
REQ-012 R_busy  output  1  high from accepted I_start until DONE entered.
REQ-013 R_done  output  1  one-cycle pulse on run completion.
REQ-014 R_err_cnt  output  16  verify mismatches, saturating at 16'hFFFF.
REQ-015 R_timeout  output  1  sticky; a busy wait exceeded POLL_MAX.

Function
REQ-016 Command encodings SHALL be: WREN 06/5'b1_0001; RDSR 05/5'b1_0011; quad page program 32/5'b1_1000; read 03/5'b1_0100; sector erase D8/5'b1_0010.
REQ-017 Handshake: a command SHALL hold R_cmd_type, R_flash_cmd, R_flash_addr, R_test_vec stable and nonzero-type until the cycle W_done_sig=1; the following cycle SHALL drive R_cmd_type=0, R_flash_cmd=0 (one idle gap) before any next command.
REQ-018 W_done_sig while R_cmd_type=0 SHALL be ignored.
REQ-019 States: IDLE, WREN, PROG, POLL, READ, DONE (plus ERASE states per REQ-031).
REQ-020 IDLE: I_start=1 SHALL latch I_pattern, clear R_err_cnt and R_timeout, set address counter to START_ADDR, set R_busy, go WREN; I_start outside IDLE SHALL be ignored.
REQ-021 WREN -> PROG on done; PROG issues one-byte program at counter address with pattern byte, -> POLL on done.
REQ-022 POLL issues RDSR repeatedly; done with W_read_data[0]=0 ends the wait; [0]=1 reissues after the idle gap and increments poll count.
REQ-023 After a program wait: if counter = START_ADDR+NUM_BYTES-1, reset counter to START_ADDR and go READ; else increment counter and go WREN.
REQ-024 READ issues read at counter; on done compare W_read_data to expected pattern byte, increment R_err_cnt on mismatch (saturate); last address -> DONE, else counter+1, stay READ.
REQ-025 Poll count reaching POLL_MAX without ready SHALL set R_timeout and go DONE directly, skipping remaining steps.
REQ-026 DONE: one cycle; pulse R_done, clear R_busy, -> IDLE; R_err_cnt and R_timeout hold until next accepted I_start.
REQ-027 Address counter SHALL be ADDR_W bits; pattern modes 2/3 use R_flash_addr[7:0].

Reset
REQ-028 I_rst=1 on a clock edge SHALL force IDLE and all outputs to 0 (R_err_cnt=0, R_timeout=0), including mid-command; driver-side abort is not this block's duty.
REQ-029 I_rst=1 with I_start=1 SHALL leave the block in IDLE.

Configuration
REQ-030 Macro FLASH_SEQ_ERASE_EN selects pre-program erase.
REQ-031 Defined: after start, sequence SHALL be WREN, ERASE (D8 at START_ADDR), POLL (timeout rules apply), then WREN/PROG loop; undefined: no erase states, start goes directly to WREN.

Verification
REQ-032 NUM_BYTES=4, START_ADDR=0x100, pattern 2, model ready on first RDSR -> programs 00,01,02,03 at 0x100..0x103, four reads, R_err_cnt=0, one R_done pulse.
REQ-033 Model returns 0x01 twice then 0x00 on RDSR -> exactly 3 RDSR per byte, idle gap (R_cmd_type=0) after each done.
REQ-034 Pattern 1, model read returns 0xFE at second address -> R_err_cnt=1 after DONE.
REQ-035 POLL_MAX=8, model always busy -> R_timeout=1 after 8 RDSR, R_done pulse, no READ commands issued.
REQ-036 I_rst asserted during PROG -> next cycle IDLE, all outputs 0; new I_start restarts at START_ADDR.
REQ-037 FLASH_SEQ_ERASE_EN defined -> first commands WREN, D8 at START_ADDR, RDSR before first 32 program.
